tick_gen_multi: RTL and testbench

Parametrised multi-channel tick generator for game timing (jump, obstacle scroll, score blink). Each channel divides clk_in by a run-time-loadable period and emits a one-cycle tick plus a square wave. An optional accelerate mode shortens a channel's period after a set number of ticks, down to a floor, so game speed ramps up. Instantiated once at top level; ticks drive the game FSMs as clock enables.

---
 rtl/tick_gen_pkg.sv | 9 +
 rtl/tick_gen_multi_if.sv | 27 ++
 rtl/tick_channel.sv | 58 +++++
 rtl/tick_gen_multi.sv | 34 +++
 tb/tb_tick_gen_multi.sv | 136 +++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared defaults for the multi-channel game tick generator.
package tick_gen_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W = 28;
  localparam int DEF_ACCEL_W = 8;
  localparam int DEF_DIV = 5_000_000;
  // One tick per second when clocked from the 50 MHz board oscillator.
  localparam int GAME_BASE_DIV = 50_000_000 - 1;
endpackage

// File: rtl/tick_gen_multi_if.sv
// tick_gen_multi_if: control and tick bus between software-side logic and the tick generator.
interface tick_gen_multi_if
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACCEL_W = DEF_ACCEL_W
);
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0] accel_en;
  logic [ACCEL_W-1:0] accel_every;
  logic [CNT_W-1:0] accel_step;
  logic [CNT_W-1:0] min_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] square;
  logic [NUM_CH*CNT_W-1:0] cur_div;
  modport master (
    output en, load, div_in, accel_en, accel_every, accel_step, min_div,
    input tick, square, cur_div
  );
  modport slave (
    input en, load, div_in, accel_en, accel_every, accel_step, min_div,
    output tick, square, cur_div
  );
endinterface

// File: rtl/tick_channel.sv
// tick_channel: one divider channel with registered tick, square wave and period ramp-down.
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACCEL_W = DEF_ACCEL_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               en,
  input  logic               load,
  input  logic               accel_en,
  input  logic [CNT_W-1:0]   div_in,
  input  logic [ACCEL_W-1:0] accel_every,
  input  logic [CNT_W-1:0]   accel_step,
  input  logic [CNT_W-1:0]   min_div,
  output logic               tick,
  output logic               square,
  output logic [CNT_W-1:0]   cur_div
);
  logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, new_div;
  logic [ACCEL_W-1:0] acc_cnt_q, acc_cnt_d;
  logic tick_q, tick_d, square_q, square_d;
  logic term, acc_go, acc_hit;
  logic [CNT_W:0] floor_sum;
  always_comb begin
    term = en & ~load & (cnt_q == div_q);
    acc_go = term & accel_en & (accel_every != '0);
    acc_hit = acc_cnt_q == accel_every - ACCEL_W'(1);
    // Extra bit keeps min_div + accel_step from wrapping.
    floor_sum = {1'b0, min_div} + {1'b0, accel_step};
    new_div = ({1'b0, div_q} > floor_sum) ? div_q - accel_step : min_div;
    cnt_d = load ? '0 : en ? (term ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    acc_cnt_d = load ? '0 : acc_go ? (acc_hit ? '0 : acc_cnt_q + ACCEL_W'(1)) : acc_cnt_q;
    div_d = load ? div_in : (acc_go && acc_hit && div_q > min_div) ? new_div : div_q;
    tick_d = term;
    square_d = square_q ^ term;
  end
  always_ff @(posedge clk_in) begin
    if (reset) begin
      cnt_q <= '0;
      div_q <= CNT_W'(DEFAULT_DIV);
      acc_cnt_q <= '0;
      tick_q <= 1'b0;
      square_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      acc_cnt_q <= acc_cnt_d;
      tick_q <= tick_d;
      square_q <= square_d;
    end
  end
  assign tick = tick_q;
  assign square = square_q;
  assign cur_div = div_q;
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NUM_CH independent tick channels sharing the accelerate settings.
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter int ACCEL_W = DEF_ACCEL_W
) (
  input logic clk_in,
  input logic reset,
  tick_gen_multi_if.slave bus
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_channel #(
      .CNT_W(CNT_W),
      .ACCEL_W(ACCEL_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in(clk_in),
      .reset(reset),
      .en(bus.en[i]),
      .load(bus.load[i]),
      .accel_en(bus.accel_en[i]),
      .div_in(bus.div_in[i*CNT_W +: CNT_W]),
      .accel_every(bus.accel_every),
      .accel_step(bus.accel_step),
      .min_div(bus.min_div),
      .tick(bus.tick[i]),
      .square(bus.square[i]),
      .cur_div(bus.cur_div[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: randomized and directed checks of tick_gen_multi against a period-level model.
module tb_tick_gen_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W = 8;
  localparam int ACCEL_W = 8;
  localparam int DEFAULT_DIV = 4;
  logic clk_in = 1'b0;
  logic reset;
  int errors = 0;
  int checks = 0;
  int m_div[NUM_CH], m_left[NUM_CH], m_ticks[NUM_CH];
  bit m_tick[NUM_CH], m_sq[NUM_CH];
  tick_gen_multi_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .ACCEL_W(ACCEL_W)) bus ();
  tick_gen_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV), .ACCEL_W(ACCEL_W)
  ) dut (
    .clk_in(clk_in),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // Model tracks cycles left until the terminal cycle of the current period.
  task automatic model_clock();
    for (int c = 0; c < NUM_CH; c++) begin
      int din = int'(bus.div_in[c*CNT_W +: CNT_W]);
      int every = int'(bus.accel_every);
      int stp = int'(bus.accel_step);
      int mn = int'(bus.min_div);
      if (reset) begin
        m_div[c] = DEFAULT_DIV; m_left[c] = DEFAULT_DIV; m_ticks[c] = 0;
        m_tick[c] = 0; m_sq[c] = 0;
      end else if (bus.load[c]) begin
        m_div[c] = din; m_left[c] = din; m_ticks[c] = 0; m_tick[c] = 0;
      end else if (bus.en[c]) begin
        m_tick[c] = (m_left[c] == 0);
        if (m_tick[c]) begin
          m_sq[c] = !m_sq[c];
          if (bus.accel_en[c] && every != 0) begin
            if (m_ticks[c] == every - 1) begin
              m_ticks[c] = 0;
              if (m_div[c] > mn) m_div[c] = (m_div[c] > mn + stp) ? m_div[c] - stp : mn;
            end else m_ticks[c] = (m_ticks[c] + 1) % 256;
          end
          m_left[c] = m_div[c];
        end else m_left[c]--;
      end else m_tick[c] = 0;
    end
  endtask
  task automatic step();
    @(posedge clk_in);
    model_clock();
    @(negedge clk_in);
    for (int c = 0; c < NUM_CH; c++) begin
      chk($sformatf("tick%0d", c), int'(bus.tick[c]), int'(m_tick[c]));
      chk($sformatf("square%0d", c), int'(bus.square[c]), int'(m_sq[c]));
      chk($sformatf("cur_div%0d", c), int'(bus.cur_div[c*CNT_W +: CNT_W]), m_div[c]);
    end
    bus.load = '0;
  endtask
  task automatic load_div(input int c, input int v);
    bus.div_in[c*CNT_W +: CNT_W] = CNT_W'(v);
    bus.load[c] = 1'b1;
  endtask
  initial begin
    int first;
    reset = 1'b1;
    bus.en = '0; bus.load = '0; bus.div_in = '0; bus.accel_en = '0;
    bus.accel_every = '0; bus.accel_step = '0; bus.min_div = '0;
    step(); step();
    chk("reset_div0", int'(bus.cur_div[CNT_W-1:0]), DEFAULT_DIV);
    reset = 1'b0;
    bus.en = 4'b0001;
    first = -1;
    for (int n = 1; n <= 20 && first < 0; n++) begin
      step();
      if (bus.tick[0]) first = n;
    end
    chk("first_tick_cycle", first, 5);
    repeat (7) step();
    load_div(0, 2);
    repeat (12) step();
    bus.en = 4'b0000;
    repeat (3) step();
    bus.en = 4'b0011;
    repeat (10) step();
    bus.accel_en = 4'b0001; bus.accel_every = 8'd2; bus.accel_step = 8'd3; bus.min_div = 8'd4;
    load_div(0, 10);
    repeat (80) step();
    chk("accel_floor", int'(bus.cur_div[CNT_W-1:0]), 4);
    load_div(0, 0);
    repeat (8) step();
    load_div(1, 1);
    repeat (3) step();
    for (int n = 0; n < 40 && !(bus.en[1] && m_left[1] == 0); n++) step();
    load_div(1, 3);
    step();
    chk("load_blocks_tick", int'(bus.tick[1]), 0);
    repeat (1500) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bus.en[c] = ($urandom_range(0, 9) != 0);
        if ($urandom_range(0, 39) == 0) load_div(c, $urandom_range(0, 12));
      end
      if ($urandom_range(0, 99) == 0) begin
        bus.accel_en = 4'($urandom);
        bus.accel_every = 8'($urandom_range(0, 4));
        bus.accel_step = 8'($urandom_range(0, 5));
        bus.min_div = 8'($urandom_range(0, 6));
      end
      step();
    end
    bus.en = '1; bus.accel_en = '1; bus.accel_every = 8'd1; bus.accel_step = 8'd1;
    repeat (7) step();
    reset = 1'b1;
    step();
    for (int c = 0; c < NUM_CH; c++) chk($sformatf("rst_div%0d", c), int'(bus.cur_div[c*CNT_W +: CNT_W]), DEFAULT_DIV);
    chk("rst_tick", int'(bus.tick), 0);
    chk("rst_square", int'(bus.square), 0);
    reset = 1'b0;
    bus.accel_en = '0;
    first = -1;
    for (int n = 1; n <= 20 && first < 0; n++) begin
      step();
      if (bus.tick[0]) first = n;
    end
    chk("first_tick_after_rst", first, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
